// File: rtl/ttl_pkg.sv
// Shared mode encodings for the clocked dual-demux / addressable-latch family.
// Pure definitions; no logic, no latency, no flow control.
package ttl_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LATCH = 2'b01,
        MODE_DEMUX = 2'b10,
        MODE_SCAN  = 2'b11
    } mode_e;

endpackage

// File: rtl/ttl_latch_bank.sv
// One 74259-style output bank: NOUT-bit register with hold/latch/demux/scan update.
// Latency 1 cycle from inputs to q; no backpressure, every edge is accepted.
module ttl_latch_bank
    import ttl_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  mode_e                      mode,
    input  logic [ADDR_W-1:0]          a,
    input  logic [ADDR_W-1:0]          cnt,
    input  logic                       g_n,
    input  logic                       d,
    output logic [(1 << ADDR_W)-1:0]   q
);

    localparam int NOUT = 1 << ADDR_W;

    logic [NOUT-1:0] r_q;
    logic [NOUT-1:0] w_onehot_a;
    logic [NOUT-1:0] w_onehot_cnt;
    logic            w_active;

    always_comb begin
        w_onehot_a        = '0;
        w_onehot_a[a]     = 1'b1;
        w_onehot_cnt      = '0;
        w_onehot_cnt[cnt] = 1'b1;
    end

    // A disabled bank, or one driven with d=0, produces an all-zero pattern in DEMUX/SCAN.
    assign w_active = !g_n && d;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            case (mode)
                MODE_LATCH: if (!g_n) r_q[a] <= d;
                MODE_DEMUX: r_q <= w_active ? w_onehot_a : '0;
                MODE_SCAN:  r_q <= w_active ? w_onehot_cnt : '0;
                default:    r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ttl_demux_latch.sv
// CHANNELS addressable-latch banks sharing one address plus a free-running scan counter.
// Latency 1 cycle to q/scan_addr/wrap; no backpressure, inputs sampled every edge.
module ttl_demux_latch
    import ttl_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int CHANNELS = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clr_n,
    input  logic [1:0]                            mode,
    input  logic [ADDR_W-1:0]                     a,
    input  logic [CHANNELS-1:0]                   g_n,
    input  logic [CHANNELS-1:0]                   d,
    output logic [CHANNELS*(1 << ADDR_W)-1:0]     q,
    output logic [ADDR_W-1:0]                     scan_addr,
    output logic                                  wrap
);

    localparam int                NOUT    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0] r_cnt;
    logic              r_wrap;
    logic              w_clr;
    mode_e             w_mode;

    assign w_clr  = reset || !clr_n;
    assign w_mode = mode_e'(mode);

    // Counter survives mode changes; only reset/clear bring it back to 0.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_mode == MODE_SCAN) begin
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= (r_cnt == CNT_MAX);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        ttl_latch_bank #(
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk  (clk),
            .clr  (w_clr),
            .mode (w_mode),
            .a    (a),
            .cnt  (r_cnt),
            .g_n  (g_n[c]),
            .d    (d[c]),
            .q    (q[c*NOUT +: NOUT])
        );
    end

    assign scan_addr = r_cnt;
    assign wrap      = r_wrap;

endmodule
